int_to_float_arbiter: RTL
=========================

Name: int_to_float_arbiter

Overview:
Shares one pipelined IntToFloat converter (MANTISSA_SIZE/EXPONENT_SIZE/INT_SIZE passed through, 4-cycle latency, no stall input) between NUM_REQ requesters. Each requester has its own valid/ready input channel. A round-robin arbiter issues at most one conversion per clock. A tag pipeline tracks which requester owns each in-flight conversion. Results land in a credit-protected output FIFO, so the converter is never stalled and no result is ever dropped.

Parameters:
- MANTISSA_SIZE, 23, mantissa width passed to converter
- EXPONENT_SIZE, 8, exponent width passed to converter; also the offset width
- INT_SIZE, 32, integer input width; must be >= MANTISSA_SIZE + 2
- NUM_REQ, 4, number of requesters; must be >= 2
- LATENCY, 4, converter latency in clocks; must match the instantiated converter
- FIFO_DEPTH, 8, result FIFO entries; must be a power of 2 and >= LATENCY + 2
- (local) ID_SIZE = $clog2(NUM_REQ); FLOAT_SIZE = 1 + EXPONENT_SIZE + MANTISSA_SIZE

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_valid  in  NUM_REQ  per-requester request valid
- s_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- s_int  in  NUM_REQ*INT_SIZE  packed signed integers; requester i at [i*INT_SIZE +: INT_SIZE]
- s_offset  in  NUM_REQ*EXPONENT_SIZE  packed signed exponent offsets; same packing
- m_valid  out  1  result valid
- m_ready  in  1  result consumer ready
- m_data  out  FLOAT_SIZE  converted float
- m_id  out  ID_SIZE  index of the requester that issued m_data
- busy  out  1  high while any conversion is in flight or any FIFO entry is held

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Reset clears the rr pointer (to 0), the tag pipeline valids, the in-flight counter and the FIFO pointers/count.
  - Out of reset: m_valid=0, s_ready=0, busy=0, m_id=0, m_data=0.
- Credit:
  - occupancy = inflight + fifo_count, using registered values only.
  - issue_ok = occupancy < FIFO_DEPTH.
  - A pop in the current cycle does not free a credit until the next cycle.
- Arbitration:
  - grant = first i with s_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - s_ready[grant] = issue_ok; all other s_ready bits are 0.
  - s_ready may depend combinationally on s_valid.
  - A transfer is s_valid[i] & s_ready[i].
  - On a transfer, rr_ptr <= grant+1 mod NUM_REQ. With no transfer, rr_ptr holds.
- Issue:
  - Converter in/offset are muxed combinationally from the granted slice; the converter registers them internally.
  - On a transfer, {1, grant} enters a LATENCY-deep tag shift register; otherwise {0, x} enters.
  - The tag and the converter output appear aligned exactly LATENCY cycles after the transfer.
- Collect:
  - A valid tag at the tail pushes {tag_id, converter out} into the FIFO.
  - A push into a full FIFO is impossible by construction. The verifier asserts it.
- FIFO:
  - Registered storage, no bypass.
  - m_valid = fifo_count != 0; m_data/m_id come from the head entry. Pop on m_valid & m_ready.
  - Simultaneous push and pop keeps the count unchanged.
  - Order is issue order.
- Latency:
  - handshake at cycle T -> push at T+LATENCY -> m_valid earliest at T+LATENCY+1 (5 by default).
  - Throughput: 1 conversion/clk sustained while m_ready=1.
- inflight counter:
  - +1 on a transfer, -1 on a tail-valid; both together leave it unchanged.
  - Width $clog2(FIFO_DEPTH+1).
- busy = (inflight != 0) | (fifo_count != 0).
- Reset mid-operation:
  - All in-flight tags and FIFO entries are discarded.
  - Stale converter outputs emerging after reset carry invalid tags and are never pushed.
  - m_valid=0 on the cycle after reset is sampled.
- Data:
  - m_data is the converter result bit-exact; the arbiter does no arithmetic on it.
  - Zero input yields all-zero exponent/mantissa with the sign bit of the input.
- m_data/m_id hold their value while m_valid=1 and m_ready=0 (AXI-stream stable).

Test Plan:
- Single requester 0: in=1, offset=0, m_ready=1 -> exactly one m_valid, 5 clocks after handshake, m_data=0x3F800000, m_id=0.
- All 4 s_valid held high with in=-2, m_ready=1 -> grants 0,1,2,3,0,1,... one per clock; every m_data=0xC0000000; m_id sequence matches grant order.
- Offset: requester 2, in=256, offset=-8 (0xF8) -> m_data=0x3F800000, m_id=2.
- Backpressure: m_ready=0 with all requesters streaming distinct values -> exactly 8 transfers accepted, then s_ready=0 for good. Raise m_ready -> 8 results in issue order, no loss or duplication; accepting resumes.
- Reset mid-flight: issue 3 requests, assert reset for 1 clock one cycle later -> m_valid=0 and busy=0 from the next cycle; no result appears for the flushed requests; the next request returns correctly with rr_ptr starting at 0.
- Throughput: requester 3 only, 100 back-to-back values 0..99, m_ready=1 -> s_ready never drops, and 100 correct results arrive on consecutive clocks (value 0 gives m_data=0x00000000).

Source files
------------

// File: rtl/int_to_float_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : int_to_float_arbiter
// Purpose  : Round-robin sharing of one pipelined int-to-float converter
//            between NUM_REQ requesters, with a credit-protected result FIFO.
// Revision : 1.0 - initial release
// ============================================================================

module int_to_float_arbiter #(
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8,
    parameter int INT_SIZE      = 32,
    parameter int NUM_REQ       = 4,
    parameter int LATENCY       = 4,
    parameter int FIFO_DEPTH    = 8,
    localparam int ID_SIZE      = $clog2(NUM_REQ),
    localparam int FLOAT_SIZE   = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                s_valid,
    output logic [NUM_REQ-1:0]                s_ready,
    input  logic [NUM_REQ*INT_SIZE-1:0]       s_int,
    input  logic [NUM_REQ*EXPONENT_SIZE-1:0]  s_offset,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [FLOAT_SIZE-1:0]             m_data,
    output logic [ID_SIZE-1:0]                m_id,
    output logic                              busy
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W   = CNT_W + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = ID_SIZE + FLOAT_SIZE;

    logic [ID_SIZE-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]         inflight_q, inflight_d;
    logic [CNT_W-1:0]         fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0]       fifo_mem_q [FIFO_DEPTH];
    logic [LATENCY-1:0]       tag_vld_q;
    logic [ID_SIZE-1:0]       tag_id_q [LATENCY];

    logic                     grant_valid;
    logic [ID_SIZE-1:0]       grant_id;
    logic [OCC_W-1:0]         occupancy;
    logic                     issue_ok;
    logic                     transfer;
    logic [INT_SIZE-1:0]      conv_in;
    logic [EXPONENT_SIZE-1:0] conv_offset;
    logic [FLOAT_SIZE-1:0]    conv_out;
    logic                     push;
    logic                     pop;
    logic [ENTRY_W-1:0]       head;

    // Credits are counted from registered state only, so a pop frees its
    // slot one cycle later and the converter can never overrun the FIFO.
    assign occupancy = OCC_W'(inflight_q) + OCC_W'(fifo_count_q);
    assign issue_ok  = occupancy < OCC_W'(FIFO_DEPTH);

    // Scan from the farthest candidate inward so the nearest valid wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (s_valid[idx]) begin
                grant_valid = 1'b1;
                grant_id    = ID_SIZE'(idx);
            end
        end
    end

    assign transfer    = grant_valid & issue_ok;
    assign s_ready     = transfer ? (NUM_REQ'(1) << grant_id) : '0;
    assign conv_in     = s_int[int'(grant_id)*INT_SIZE +: INT_SIZE];
    assign conv_offset = s_offset[int'(grant_id)*EXPONENT_SIZE +: EXPONENT_SIZE];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (transfer) begin
            rr_ptr_d = (grant_id == ID_SIZE'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    int_to_float_pipe #(
        .MANTISSA_SIZE (MANTISSA_SIZE),
        .EXPONENT_SIZE (EXPONENT_SIZE),
        .INT_SIZE      (INT_SIZE)
    ) u_conv (
        .clk      (clk),
        .in_i     (conv_in),
        .offset_i (conv_offset),
        .out_o    (conv_out)
    );

    // Tag pipeline mirrors the converter depth so ownership lines up with data.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld_q <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[LATENCY-2:0], transfer};
        end
    end

    always_ff @(posedge clk) begin
        tag_id_q[0] <= transfer ? grant_id : '0;
        for (int i = 1; i < LATENCY; i++) begin
            tag_id_q[i] <= tag_id_q[i-1];
        end
    end

    assign push = tag_vld_q[LATENCY-1];
    assign pop  = m_valid & m_ready;

    always_comb begin
        inflight_d   = inflight_q + CNT_W'(transfer) - CNT_W'(push);
        fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            inflight_q   <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            inflight_q   <= inflight_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {tag_id_q[LATENCY-1], conv_out};
        end
    end

    // Storage is not reset; outputs are gated so they read zero when empty.
    assign head    = fifo_mem_q[rd_ptr_q];
    assign m_valid = (fifo_count_q != '0);
    assign m_data  = m_valid ? head[FLOAT_SIZE-1:0] : '0;
    assign m_id    = m_valid ? head[ENTRY_W-1:FLOAT_SIZE] : '0;
    assign busy    = (inflight_q != '0) | (fifo_count_q != '0);

endmodule

// ============================================================================
// Module   : int_to_float_pipe
// Purpose  : Four-stage signed integer to float converter, result scaled by
//            2**offset, round-to-nearest-even, denormals flushed to zero.
// Revision : 1.0 - initial release
// ============================================================================

module int_to_float_pipe #(
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8,
    parameter int INT_SIZE      = 32,
    localparam int FLOAT_SIZE   = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
    input  logic                     clk,
    input  logic [INT_SIZE-1:0]      in_i,
    input  logic [EXPONENT_SIZE-1:0] offset_i,
    output logic [FLOAT_SIZE-1:0]    out_o
);

    localparam int MSB_W   = $clog2(INT_SIZE);
    localparam int SH_W    = MSB_W + 1;
    localparam int EW      = EXPONENT_SIZE + MSB_W + 2;
    localparam int BIAS    = 2**(EXPONENT_SIZE - 1) - 1;
    localparam int EXP_MAX = 2**EXPONENT_SIZE - 1;

    logic                     a_sign_q;
    logic [INT_SIZE-1:0]      a_mag_q;
    logic [EXPONENT_SIZE-1:0] a_off_q;

    logic                     b_sign_q, b_zero_q;
    logic [INT_SIZE-1:0]      b_mag_q;
    logic [MSB_W-1:0]         b_msb_q;
    logic [EXPONENT_SIZE-1:0] b_off_q;

    logic                     c_sign_q, c_zero_q;
    logic [MANTISSA_SIZE-1:0] c_mant_q;
    logic [EW-1:0]            c_exp_q;

    logic [FLOAT_SIZE-1:0]    out_q, out_d;

    logic [MSB_W-1:0]         msb;
    logic [SH_W-1:0]          shamt;
    logic [INT_SIZE-1:0]      frac;
    logic [MANTISSA_SIZE-1:0] mant_trunc;
    logic                     guard_bit, sticky_bit, round_up;
    logic [MANTISSA_SIZE:0]   mant_sum;
    logic [EW-1:0]            exp_sum;

    always_ff @(posedge clk) begin
        a_sign_q <= in_i[INT_SIZE-1];
        a_mag_q  <= in_i[INT_SIZE-1] ? (~in_i + 1'b1) : in_i;
        a_off_q  <= offset_i;
    end

    always_comb begin
        msb = '0;
        for (int i = 0; i < INT_SIZE; i++) begin
            if (a_mag_q[i]) begin
                msb = MSB_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        b_sign_q <= a_sign_q;
        b_zero_q <= (a_mag_q == '0);
        b_mag_q  <= a_mag_q;
        b_msb_q  <= msb;
        b_off_q  <= a_off_q;
    end

    // Shifting past the leading one leaves only fraction bits, left-aligned.
    always_comb begin
        shamt      = SH_W'(INT_SIZE) - {1'b0, b_msb_q};
        frac       = b_mag_q << shamt;
        mant_trunc = frac[INT_SIZE-1 -: MANTISSA_SIZE];
        guard_bit  = frac[INT_SIZE-1-MANTISSA_SIZE];
        sticky_bit = |frac[INT_SIZE-2-MANTISSA_SIZE:0];
        round_up   = guard_bit & (sticky_bit | mant_trunc[0]);
        mant_sum   = {1'b0, mant_trunc} + (MANTISSA_SIZE+1)'(round_up);
        exp_sum    = EW'(BIAS)
                   + {{(EW-MSB_W){1'b0}}, b_msb_q}
                   + {{(EW-EXPONENT_SIZE){b_off_q[EXPONENT_SIZE-1]}}, b_off_q}
                   + {{(EW-1){1'b0}}, mant_sum[MANTISSA_SIZE]};
    end

    always_ff @(posedge clk) begin
        c_sign_q <= b_sign_q;
        c_zero_q <= b_zero_q;
        c_mant_q <= mant_sum[MANTISSA_SIZE-1:0];
        c_exp_q  <= exp_sum;
    end

    // Underflow flushes to signed zero, overflow saturates to infinity.
    always_comb begin
        out_d = {c_sign_q, c_exp_q[EXPONENT_SIZE-1:0], c_mant_q};
        if (c_zero_q || c_exp_q[EW-1] || (c_exp_q == '0)) begin
            out_d = {c_sign_q, {(FLOAT_SIZE-1){1'b0}}};
        end else if ($signed(c_exp_q) >= $signed(EW'(EXP_MAX))) begin
            out_d = {c_sign_q, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        out_q <= out_d;
    end

    assign out_o = out_q;

endmodule

`default_nettype wire
